// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS ramp controllers: register map, CTRL/STATUS bits, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dds_ctrl_pkg;

    // Avalon word addresses
    localparam int REG_TARGET  = 0;
    localparam int REG_STEP    = 1;
    localparam int REG_CTRL    = 2;
    localparam int REG_STATUS  = 3;
    localparam int REG_CURRENT = 4;

    // CTRL bits (GO/ABORT/IMMEDIATE are strobes, IRQ_EN is stored)
    localparam int CTRL_GO     = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IMM    = 2;
    localparam int CTRL_IRQ_EN = 3;

    // STATUS bits
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

endpackage

// File: rtl/dds_ramp_step.sv
// Combinational ramp step: moves cur one step toward tgt, snapping to tgt when within one step.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module dds_ramp_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] tgt,
    input  logic [DW-1:0] step,
    output logic [DW-1:0] nxt,
    output logic          reached
);

    logic          w_up;
    logic [DW-1:0] w_diff;

    // Direction is decided before subtracting so the distance never wraps; snapping when
    // the distance fits inside one step guarantees no overshoot past tgt and no wrap of nxt.
    always_comb begin
        w_up    = (tgt > cur);
        w_diff  = w_up ? (tgt - cur) : (cur - tgt);
        reached = (w_diff <= step) || (step == '0);
        if (reached) begin
            nxt = tgt;
        end else if (w_up) begin
            nxt = cur + step;
        end else begin
            nxt = cur - step;
        end
    end

endmodule

// File: rtl/dds_am_index_ramp_ctrl.sv
// Avalon-MM slave that ramps the DDS AM modulation index toward a target, one step per sample tick.
// Latency: register writes land on the next clk edge; first ramp step on the first tick after GO.
// Backpressure: none; zero-wait-state slave, sample_tick is a non-blocking strobe.
module dds_am_index_ramp_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    input  logic          sample_tick,
    output logic [DW-1:0] mod_index,
    output logic          busy,
    output logic          irq
);

    logic [DW-1:0] r_target;
    logic [DW-1:0] r_step;
    logic [DW-1:0] r_mod_index;
    logic          r_irq_en;
    logic          r_done;
    state_t        r_state;

    logic          w_wr;
    logic          w_wr_target;
    logic          w_wr_step;
    logic          w_wr_ctrl;
    logic          w_go;
    logic          w_abort;
    logic          w_imm;
    logic [DW-1:0] w_step_nxt;
    logic          w_reached;
    state_t        w_state_nxt;
    logic [DW-1:0] w_mod_nxt;
    logic          w_done_nxt;
    logic [31:0]   w_rdata;

    // Write decode: a write is chipselect with write_n low; CTRL strobes live one cycle.
    always_comb begin
        w_wr        = chipselect && !write_n;
        w_wr_target = w_wr && (address == AW'(REG_TARGET));
        w_wr_step   = w_wr && (address == AW'(REG_STEP));
        w_wr_ctrl   = w_wr && (address == AW'(REG_CTRL));
        w_go        = w_wr_ctrl && writedata[CTRL_GO];
        w_abort     = w_wr_ctrl && writedata[CTRL_ABORT];
        w_imm       = w_wr_ctrl && writedata[CTRL_IMM];
    end

    dds_ramp_step #(
        .DW (DW)
    ) u_step (
        .cur     (r_mod_index),
        .tgt     (r_target),
        .step    (r_step),
        .nxt     (w_step_nxt),
        .reached (w_reached)
    );

    // Software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_target <= '0;
            r_step   <= '0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_wr_target) r_target <= DW'(writedata);
            if (w_wr_step)   r_step   <= DW'(writedata);
            if (w_wr_ctrl)   r_irq_en <= writedata[CTRL_IRQ_EN];
        end
    end

    // FSM state and ramp datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mod_index <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mod_index <= w_mod_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next state: ticks advance the ramp; ABORT overrides everything and freezes the index.
    // GO only acts from IDLE; in RAMP done is already clear so GO has nothing left to do.
    // A tick in the GO cycle sees IDLE and is therefore ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_mod_nxt   = r_mod_index;
        w_done_nxt  = r_done;
        if ((r_state == RAMP) && sample_tick) begin
            w_mod_nxt = w_step_nxt;
            if (w_reached) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
        end
        if (w_abort) begin
            w_state_nxt = IDLE;
            w_mod_nxt   = r_mod_index;
        end else if (w_go && (r_state == IDLE)) begin
            w_done_nxt = 1'b0;
            if (w_imm) begin
                w_mod_nxt  = r_target;
                w_done_nxt = 1'b1;
            end else begin
                w_state_nxt = RAMP;
            end
        end
    end

    // Combinational read mux; unmapped and strobe-only bits read as zero.
    always_comb begin
        w_rdata = '0;
        case (address)
            AW'(REG_TARGET):  w_rdata = 32'(r_target);
            AW'(REG_STEP):    w_rdata = 32'(r_step);
            AW'(REG_CTRL):    w_rdata[CTRL_IRQ_EN] = r_irq_en;
            AW'(REG_STATUS): begin
                w_rdata[STAT_BUSY] = (r_state == RAMP);
                w_rdata[STAT_DONE] = r_done;
            end
            AW'(REG_CURRENT): w_rdata = 32'(r_mod_index);
            default:          w_rdata = '0;
        endcase
    end

    assign readdata  = w_rdata;
    assign mod_index = r_mod_index;
    assign busy      = (r_state == RAMP);
    assign irq       = r_done && r_irq_en;

endmodule

// File: tb/tb_dds_am_index_ramp_ctrl.sv
// Directed bench for the AM index ramp controller.
// Latency: checks sampled on the falling edge after each driven rising edge.
// Backpressure: none exercised; the slave has no wait states.
module tb_dds_am_index_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        sample_tick;
    logic [31:0] mod_index;
    logic        busy;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dds_am_index_ramp_ctrl #(
        .DW (32),
        .AW (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .sample_tick (sample_tick),
        .mod_index   (mod_index),
        .busy        (busy),
        .irq         (irq)
    );

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        total++; if (mod_index !== 32'd0) begin bad++; $display("FAIL reset_mod: got %0d want 0", mod_index); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_read%0d: got %h want 0", i, d); end
        end
        wr(3'd5, 32'hDEAD_BEEF);
        rd(3'd5, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL ro_addr5: got %h want 0", d); end
        wr(3'd4, 32'h1234);
        total++; if (mod_index !== 32'd0) begin bad++; $display("FAIL ro_current: got %0d want 0", mod_index); end
    endtask

    task automatic test_up_ramp();
        logic [31:0] exp_seq [4] = '{32'd30, 32'd60, 32'd90, 32'd100};
        logic [31:0] prev = 32'd0;
        logic [31:0] d;
        wr(3'd0, 32'd100);
        wr(3'd1, 32'd30);
        wr(3'd2, 32'h9);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL up_busy_start: got %b want 1", busy); end
        for (int k = 0; k < 4; k++) begin
            idle(4);
            total++; if (mod_index !== prev) begin bad++; $display("FAIL up_hold%0d: got %0d want %0d", k, mod_index, prev); end
            tick();
            total++; if (mod_index !== exp_seq[k]) begin bad++; $display("FAIL up_step%0d: got %0d want %0d", k, mod_index, exp_seq[k]); end
            total++; if (busy !== (k < 3)) begin bad++; $display("FAIL up_busy%0d: got %b want %b", k, busy, (k < 3)); end
            prev = exp_seq[k];
        end
        rd(3'd3, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL up_status: got %h want 2", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL up_irq: got %b want 1", irq); end
        rd(3'd2, d);
        total++; if (d !== 32'h8) begin bad++; $display("FAIL up_ctrl_rb: got %h want 8", d); end
    endtask

    task automatic test_down_and_wrap();
        logic [31:0] exp_seq [3] = '{32'd60, 32'd20, 32'd10};
        logic [31:0] e;
        logic [31:0] d;
        wr(3'd0, 32'd10);
        wr(3'd1, 32'd40);
        // GO issued together with a tick: that tick must not move the index
        sample_tick = 1'b1;
        wr(3'd2, 32'h9);
        sample_tick = 1'b0;
        total++; if (mod_index !== 32'd100) begin bad++; $display("FAIL down_go_tick: got %0d want 100", mod_index); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL down_irq_clr: got %b want 0", irq); end
        for (int k = 0; k < 3; k++) begin
            idle(2);
            tick();
            total++; if (mod_index !== exp_seq[k]) begin bad++; $display("FAIL down_step%0d: got %0d want %0d", k, mod_index, exp_seq[k]); end
        end
        rd(3'd3, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL down_status: got %h want 2", d); end
        wr(3'd0, 32'hFFFF_FF00);
        wr(3'd2, 32'hD);
        total++; if (mod_index !== 32'hFFFF_FF00) begin bad++; $display("FAIL wrap_preload: got %h want ffffff00", mod_index); end
        wr(3'd0, 32'hFFFF_FFF0);
        wr(3'd1, 32'h20);
        wr(3'd2, 32'h9);
        e = 32'hFFFF_FF00;
        for (int k = 0; k < 8; k++) begin
            tick();
            if ((32'hFFFF_FFF0 - e) > 32'h20) e = e + 32'h20;
            else e = 32'hFFFF_FFF0;
            total++; if (mod_index !== e) begin bad++; $display("FAIL wrap_step%0d: got %h want %h", k, mod_index, e); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_busy: got %b want 0", busy); end
    endtask

    task automatic test_step_zero_and_imm();
        logic [31:0] d;
        wr(3'd0, 32'd500);
        wr(3'd1, 32'd0);
        wr(3'd2, 32'h1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy: got %b want 1", busy); end
        tick();
        total++; if (mod_index !== 32'd500) begin bad++; $display("FAIL zero_snap: got %0d want 500", mod_index); end
        rd(3'd3, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL zero_status: got %h want 2", d); end
        wr(3'd0, 32'd7);
        wr(3'd2, 32'h5);
        total++; if (mod_index !== 32'd7) begin bad++; $display("FAIL imm_load: got %0d want 7", mod_index); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL imm_busy: got %b want 0", busy); end
        rd(3'd3, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL imm_status: got %h want 2", d); end
    endtask

    task automatic test_retarget_and_abort();
        logic [31:0] d;
        wr(3'd0, 32'd0);
        wr(3'd2, 32'h5);
        wr(3'd0, 32'd1000);
        wr(3'd1, 32'd20);
        wr(3'd2, 32'h9);
        tick();
        tick();
        total++; if (mod_index !== 32'd40) begin bad++; $display("FAIL retgt_pre: got %0d want 40", mod_index); end
        wr(3'd0, 32'd50);
        total++; if (mod_index !== 32'd40) begin bad++; $display("FAIL retgt_hold: got %0d want 40", mod_index); end
        tick();
        total++; if (mod_index !== 32'd50) begin bad++; $display("FAIL retgt_snap: got %0d want 50", mod_index); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL retgt_busy: got %b want 0", busy); end
        wr(3'd0, 32'd1000);
        wr(3'd2, 32'h9);
        tick();
        total++; if (mod_index !== 32'd70) begin bad++; $display("FAIL abort_pre: got %0d want 70", mod_index); end
        wr(3'd2, 32'hB);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        tick();
        total++; if (mod_index !== 32'd70) begin bad++; $display("FAIL abort_frozen: got %0d want 70", mod_index); end
        rd(3'd3, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_status: got %h want 0", d); end
    endtask

    task automatic test_reset_mid_ramp();
        logic [31:0] d;
        wr(3'd0, 32'd0);
        wr(3'd2, 32'hD);
        wr(3'd0, 32'd200);
        wr(3'd1, 32'd30);
        wr(3'd2, 32'h9);
        tick();
        tick();
        total++; if (mod_index !== 32'd60 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got %0d/%b want 60/1", mod_index, busy); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (mod_index !== 32'd0) begin bad++; $display("FAIL rstmid_mod: got %0d want 0", mod_index); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rstmid_irq: got %b want 0", irq); end
        reset = 1'b0;
        rd(3'd0, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rstmid_target: got %0d want 0", d); end
        rd(3'd2, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rstmid_ctrl: got %h want 0", d); end
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_up_ramp();
        test_down_and_wrap();
        test_step_zero_and_imm();
        test_retarget_and_abort();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_am_index_ramp_ctrl.md
Name: dds_am_index_ramp_ctrl

Overview:
- Avalon-MM slave that sequences the DDS AM modulation index.
- Software writes a target index and a step size, then issues GO. The block then ramps the live mod_index output toward the target, one step per DDS sample strobe, so index changes are click-free.
- Sits between the NiosII Avalon fabric and the DDS AM multiplier, replacing a direct PIO-driven index.

Parameters:
- DW, 32, width of the index, target and step registers.
- AW, 3, Avalon word-address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  AW  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, combinational, zero wait states.
- sample_tick  in  1  one-cycle DDS sample strobe; the ramp advances only on this strobe.
- mod_index  out  DW  live modulation index to the AM datapath.
- busy  out  1  high while a ramp is in progress.
- irq  out  1  level interrupt, equal to done AND irq_en.

Behaviour:
- Register map (word addresses):
  - 0 TARGET (RW).
  - 1 STEP (RW).
  - 2 CTRL, write-only strobes: bit0 GO, bit1 ABORT, bit2 IMMEDIATE; bit3 IRQ_EN is stored and read back.
  - 3 STATUS (RO): bit0 busy, bit1 done.
  - 4 CURRENT (RO): mod_index.
  - 5–7 read 0; writes to 3–7 are ignored.
- Write qualification: a write occurs when chipselect=1 and write_n=0. Register update happens at the next clk edge.
- Reset: TARGET, STEP, mod_index, irq_en and done all go to 0, and state goes to IDLE. Outputs after reset: busy=0, irq=0, mod_index=0.
- State IDLE:
  - CTRL write with GO=1 and IMMEDIATE=0: state goes to RAMP and done is cleared.
  - CTRL write with GO=1 and IMMEDIATE=1: mod_index loads TARGET on the next clk edge, done is set, and state stays IDLE.
- State RAMP, evaluated only on cycles where sample_tick=1:
  - Compute diff = |TARGET − mod_index| (unsigned DW-bit values, compared before subtraction; no wrap).
  - If diff ≤ STEP, or STEP = 0: mod_index = TARGET, done = 1, state goes to IDLE.
  - Otherwise mod_index moves by STEP toward TARGET.
  - Overshoot and arithmetic wrap are impossible by construction.
- Latency: the first step lands on the first sample_tick strictly after the GO write edge. A tick coinciding with the GO write cycle is not used.
- Writes to TARGET or STEP during RAMP take effect at the next tick evaluation, so the ramp re-aims toward the new target.
- GO while already in RAMP: no effect other than keeping done=0.
- ABORT (any state): state goes to IDLE, mod_index freezes, done is unchanged.
- GO and ABORT in the same write: ABORT wins.
- done is cleared only by a GO write or by reset.
- busy = (state == RAMP).
- mod_index changes only on an accepted tick, an IMMEDIATE GO, or reset. It never glitches.
- Reset asserted mid-ramp: the block returns to the reset values above on the next clk edge.

Decomposition:
- Shared package dds_ctrl_pkg holds:
  - register address constants (REG_TARGET=0 … REG_CURRENT=4);
  - CTRL/STATUS bit indices;
  - state enum {IDLE, RAMP}.
- One natural sub-module, dds_ramp_step: combinational step calculator.
  - Inputs: cur, tgt, step.
  - Outputs: nxt, reached.
  - Reused later by the FM-deviation and amplitude ramp controllers.

Test Plan:
1. Reset, then read addresses 0–7 → all reads 0; mod_index=0, busy=0, irq=0.
2. TARGET=100, STEP=30, CTRL=GO|IRQ_EN, four ticks spaced 5 cycles apart → mod_index goes 30, 60, 90, 100. busy drops on the 4th tick, done=1, irq=1. Ticks in between leave mod_index unchanged.
3. Downward ramp: current=100, TARGET=10, STEP=40, GO, three ticks → mod_index goes 60, 20, 10, then done is set. Also TARGET=0xFFFFFFF0, STEP=0x20 from 0xFFFFFF00 → no wrap; mod_index ends exactly at 0xFFFFFFF0.
4. STEP=0 with TARGET=500, GO, one tick → mod_index=500 and done=1. IMMEDIATE GO with TARGET=7 and no tick → mod_index=7 one clk later, busy never asserts.
5. Mid-ramp, write TARGET=50 (ramp from 0 toward 1000, STEP=20, currently at 40) → next tick gives 50 and done. A separate run with CTRL=GO|ABORT in one write → state stays IDLE, mod_index is frozen, done=0.
6. Reset asserted while busy at mod_index=60 → next edge gives mod_index=0, busy=0, irq=0, and TARGET reads back 0.
